core_run_sequencer: RTL
=======================

CORE_RUN_SEQUENCER -- requirements
Module: core_run_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, width of the observed ir and pc buses.
REQ-002 The block SHALL have parameter N_RST, default 7, number of core reset lines (rst_ir, rst_pc, rst_alu_out, rst_mdr, rst_ABC[2:0]).
REQ-003 The block SHALL have parameter RST_CYCLES, default 2, cycles core resets are held after go (legal range 1..255).
REQ-004 The block SHALL have parameter MAX_CYCLES, default 20, run-cycle budget before timeout (legal range 1..2^CNT_W-1).
REQ-005 The block SHALL have parameter STALL_CYCLES, default 8, consecutive unchanged-pc cycles that declare a stall (legal range 2..255).
REQ-006 The block SHALL have parameter HALT_INSTR, default 16'hFFFF, instruction word that ends a run.
REQ-007 The block SHALL have parameter CNT_W, default 16, cycle_count width.
REQ-008 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-009 Port: rst  input  1  synchronous, active-high reset.
REQ-010 Port: go  input  1  start/restart request, sampled in IDLE and DONE.
REQ-011 Port: abort  input  1  returns the sequencer to IDLE from any state.
REQ-012 Port: ir  input  DATA_W  current core instruction register.
REQ-013 Port: pc  input  DATA_W  current core program counter.
REQ-014 Port: core_rst  output  N_RST  reset lines to the data path, all bits driven identically.
REQ-015 Port: strt  output  1  core start enable.
REQ-016 Port: busy, done, timeout, stalled  output  1 each  status flags.
REQ-017 Port: cycle_count  output  CNT_W  RUN cycles elapsed.

Function
REQ-018 The block SHALL implement states IDLE, RESET, RUN and DONE; all outputs SHALL be registered.
REQ-019 In IDLE: core_rst all ones, strt=0, busy=0; on go=1 the block SHALL go to RESET and clear done/timeout/stalled/cycle_count.
REQ-020 In RESET: core_rst all ones, strt=0, busy=1; after exactly RST_CYCLES cycles in RESET the block SHALL enter RUN.
REQ-021 In RUN: core_rst all zeros, strt=1, busy=1; cycle_count SHALL be 0 in the first RUN cycle and increment by 1 each subsequent RUN cycle.
REQ-022 In RUN, ir==HALT_INSTR SHALL move to DONE with done=1 on the next edge.
REQ-023 In RUN, pc equal to its previous-cycle value for STALL_CYCLES consecutive cycles SHALL move to DONE with stalled=1; any pc change SHALL restart the stall count at 0.
REQ-024 In RUN, cycle_count==MAX_CYCLES-1 SHALL move to DONE with timeout=1.
REQ-025 Simultaneous exit conditions SHALL be prioritised halt > stall > timeout; exactly one of done/stalled/timeout SHALL be set.
REQ-026 In DONE: core_rst all zeros, strt=0, busy=0; flags and cycle_count SHALL hold (sticky) for inspection.
REQ-027 In DONE, go=1 SHALL enter RESET, clearing flags and cycle_count as in REQ-019.
REQ-028 abort=1 SHALL move any state to IDLE on the next edge, clearing flags; abort SHALL take priority over go and all RUN exit conditions.
REQ-029 cycle_count SHALL never wrap; MAX_CYCLES bounds it below 2^CNT_W.

Reset
REQ-030 rst=1 SHALL, on the next clk edge, force IDLE, core_rst all ones, strt=0, busy=0, done=0, timeout=0, stalled=0, cycle_count=0, stall counter=0, including mid-RUN.
REQ-031 rst SHALL take priority over abort and go.

Verification
REQ-032 Defaults, go pulse at cycle 0 -> core_rst=7'h7F for cycles 1-2, strt=1 from cycle 3, cycle_count=0 at cycle 3.
REQ-033 RUN with pc incrementing, ir=16'hFFFF at cycle_count=5 -> next cycle done=1, strt=0, cycle_count holds 5.
REQ-034 RUN with pc incrementing, never halting -> timeout=1 after cycle_count reaches 19, strt=0, done=0.
REQ-035 pc frozen at 16'h0004 from cycle_count=3 -> stalled=1 after 8 unchanged cycles; same cycle as timeout with MAX_CYCLES=11 -> stalled wins.
REQ-036 rst asserted at cycle_count=7 in RUN -> next edge IDLE, core_rst=7'h7F, all flags and cycle_count 0; abort mid-RESET -> IDLE, no RUN entered.
REQ-037 In DONE, go=1 -> RESET for 2 cycles, flags cleared, fresh run with cycle_count restarting at 0.

Source files
------------

// File: rtl/core_run_sequencer_if.sv
// rtl/core_run_sequencer_if.sv - control/status bundle between run sequencer and its host
// The host drives go/abort and mirrors the core's ir/pc; the sequencer returns core controls and status.
interface core_run_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int N_RST  = 7,
  parameter int CNT_W  = 16
);
  logic              go;
  logic              abort;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] pc;
  logic [N_RST-1:0]  core_rst;
  logic              strt;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              stalled;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output go, abort, ir, pc,
    input  core_rst, strt, busy, done, timeout, stalled, cycle_count
  );

  modport slave (
    input  go, abort, ir, pc,
    output core_rst, strt, busy, done, timeout, stalled, cycle_count
  );
endinterface

// File: rtl/core_run_sequencer.sv
// rtl/core_run_sequencer.sv - resets, starts and supervises one run of a small core
// Ends the run on halt instruction, stalled pc or cycle budget; all outputs registered.
module core_run_sequencer #(
  parameter int                DATA_W       = 16,
  parameter int                N_RST        = 7,
  parameter int                RST_CYCLES   = 2,
  parameter int                MAX_CYCLES   = 20,
  parameter int                STALL_CYCLES = 8,
  parameter logic [DATA_W-1:0] HALT_INSTR   = 16'hFFFF,
  parameter int                CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  core_run_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0]       RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0]       STALL_LAST = 8'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CC_LAST    = CNT_W'(MAX_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        rst_cnt_q, rst_cnt_d;
  logic [7:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  cc_q, cc_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              stalled_q, stalled_d;
  logic [DATA_W-1:0] prev_pc_q;
  logic [N_RST-1:0]  core_rst_q;
  logic              strt_q;
  logic              busy_q;
  logic              pc_same;

  assign pc_same = (bus.pc == prev_pc_q);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    cc_d        = cc_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    stalled_d   = stalled_q;

    if (bus.abort) begin
      state_d     = S_IDLE;
      rst_cnt_d   = '0;
      stall_cnt_d = '0;
      cc_d        = '0;
      done_d      = 1'b0;
      timeout_d   = 1'b0;
      stalled_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.go) begin
            state_d     = S_RESET;
            rst_cnt_d   = '0;
            stall_cnt_d = '0;
            cc_d        = '0;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
            stalled_d   = 1'b0;
          end
        end
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d     = S_RUN;
            stall_cnt_d = '0;
            cc_d        = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          // Exit priority: halt, then stall, then budget; cycle_count freezes at the exit cycle.
          if (bus.ir == HALT_INSTR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (pc_same && (stall_cnt_q == STALL_LAST)) begin
            state_d   = S_DONE;
            stalled_d = 1'b1;
          end else if (cc_q == CC_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else begin
            cc_d        = cc_q + 1'b1;
            stall_cnt_d = pc_same ? stall_cnt_q + 8'd1 : 8'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      stall_cnt_q <= '0;
      cc_q        <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      stalled_q   <= 1'b0;
      prev_pc_q   <= '0;
      core_rst_q  <= '1;
      strt_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      cc_q        <= cc_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      stalled_q   <= stalled_d;
      prev_pc_q   <= bus.pc;
      // Control outputs follow the state being entered so they line up with it.
      core_rst_q  <= {N_RST{(state_d == S_IDLE) || (state_d == S_RESET)}};
      strt_q      <= (state_d == S_RUN);
      busy_q      <= (state_d == S_RESET) || (state_d == S_RUN);
    end
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.strt        = strt_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.stalled     = stalled_q;
  assign bus.cycle_count = cc_q;

endmodule
